// File: rtl/multiword_add_ctrl.sv
// Wide add/subtract sequenced over a single SIZE-bit adder, one word per cycle,
// least significant word first, with the carry fed forward between words.
module multiword_add_ctrl #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sub,
    input  logic [SIZE*WORDS-1:0]   a,
    input  logic [SIZE*WORDS-1:0]   b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [SIZE*WORDS-1:0]   s,
    output logic                    cout,
    output logic                    ovf
);

    localparam int unsigned W  = SIZE * WORDS;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;

    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    psum;
    logic [W-1:0]    psum_upd;
    logic            carry;
    logic [KW-1:0]   k;
    logic [SIZE-1:0] word_a;
    logic [SIZE-1:0] word_b;
    logic [SIZE:0]   sum_ext;
    logic            last;

    // Word select, the single shared adder, and the partial-sum merge.
    always_comb begin
        word_a   = '0;
        word_b   = '0;
        psum_upd = psum;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (k == KW'(i)) begin
                word_a = a_r[i*SIZE +: SIZE];
                word_b = b_r[i*SIZE +: SIZE];
            end
        end
        sum_ext = {1'b0, word_a} + {1'b0, word_b} + (SIZE+1)'(carry);
        for (int i = 0; i < int'(WORDS); i++) begin
            if (k == KW'(i)) begin
                psum_upd[i*SIZE +: SIZE] = sum_ext[SIZE-1:0];
            end
        end
        last = (k == KW'(WORDS - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, word iteration and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            k     <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_d == ADD);
            done <= (state_d == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        k     <= '0;
                    end
                end
                ADD: begin
                    psum  <= psum_upd;
                    carry <= sum_ext[SIZE];
                    k     <= k + KW'(1);
                    if (last) begin
                        s    <= psum_upd;
                        cout <= sum_ext[SIZE];
                        // b_r already holds ~b for subtraction, so one rule covers both.
                        ovf  <= (a_r[W-1] == b_r[W-1]) && (sum_ext[SIZE-1] != a_r[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multiword_add_ctrl.md
Name: multiword_add_ctrl

Overview:
- Sequencing controller that adds or subtracts two WORDS*SIZE-bit operands using a single SIZE-bit adder.
- Processes one SIZE-bit word per cycle, least significant word first, and feeds each carry-out back into the next word's carry-in.
- Lets wide arithmetic reuse a narrow adder datapath at the cost of WORDS cycles of latency.
- Issues a one-cycle done pulse with registered sum, carry and signed-overflow results.

Parameters:
- SIZE, 8: width of the shared adder in bits (one word).
- WORDS, 4: number of words per operand; must be at least 1. Full operand width is W = SIZE*WORDS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- cin  input  1  carry-in for addition; ignored when sub=1.
- busy  output  1  high while words are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- s  output  W  result; held until the next completion.
- cout  output  1  final carry-out (for subtraction, 1 = no borrow).
- ovf  output  1  two's-complement signed overflow of the W-bit operation.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - busy, done, s, cout and ovf all go to 0.
  - Internal operand, partial-sum, carry and index registers are cleared.
  - Reset has priority over start and over any operation in progress (an abort).
- States: IDLE, ADD, DONE.
- IDLE:
  - If start=1 at an edge, capture a_r=a and b_r = sub ? ~b : b.
  - Set carry = sub ? 1 : cin, and k=0.
  - Go to ADD; busy=1 from the next cycle.
- ADD:
  - Each edge computes {c, w} = a_r[k] + b_r[k] + carry on the single SIZE-bit adder.
  - Write w into partial word k of an internal partial-sum register, then set carry=c and increment k.
  - Exactly one adder evaluation per cycle; no multi-word combinational chaining.
  - On the edge where k==WORDS-1:
    - Copy the completed partial-sum register into s.
    - Set cout=c.
    - Set ovf = (a_r[W-1]==b_r[W-1]) && (final sum MSB != a_r[W-1]).
    - Go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency: start sampled at edge E0 → ADD during edges E1..E_WORDS → done high in the cycle after E_WORDS. busy is high for exactly WORDS cycles.
- Output stability: s, cout and ovf change only at completion or reset. They are never driven with partial results and hold after done until the next completion.
- Overlapping starts: start while busy or in DONE is ignored, with no queuing. start is accepted again in the first IDLE cycle after DONE, giving a throughput of one operation per WORDS+2 cycles.
- Operand isolation: changes on a, b, sub or cin after capture do not affect the operation in flight.
- WORDS=1: ADD lasts one cycle and done appears 1 cycle after the start edge.
- Arithmetic is modulo 2^W. ovf and cout are independent flags.

Test Plan:
(SIZE=8, WORDS=4 throughout)
1. a=0x000000FF, b=0x00000001, cin=0, sub=0 → s=0x00000100, cout=0, ovf=0. busy high 4 cycles; done pulses exactly 4 cycles after the start edge.
2. a=0xFFFFFFFF, b=0x00000001, cin=0 → s=0x00000000, cout=1, ovf=0 (carry ripples through all 4 words). Also a=0, b=0, cin=1 → s=0x00000001.
3. a=0x7FFFFFFF, b=0x00000001 → s=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 → s=0, cout=1, ovf=1.
4. sub=1:
   - a=7, b=5 → s=0x00000002, cout=1, ovf=0.
   - a=5, b=7 → s=0xFFFFFFFE, cout=0, ovf=0.
   - a=0x80000000, b=1 → s=0x7FFFFFFF, ovf=1.
   - cin=1 in every case produces the same results (cin ignored).
5. Pulse start with new operands during ADD and during DONE, and change a/b mid-operation → both starts ignored; the result matches the operands captured originally. A start in the first IDLE cycle afterwards is accepted.
6. Drive rst_n=0 at the 2nd ADD edge → next cycle all outputs are 0, no done pulse, state IDLE. Issuing a=1, b=1 then gives s=2 with correct 4-cycle latency.
